sram_controller: RTL and testbench



---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_controller.sv | 124 ++++++++++++
 tb/tb_sram_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and widths for the external 16-bit SRAM initiator.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W       = 18;
  localparam int unsigned SRAM_DATA_W       = 16;
  localparam int unsigned WORD_W            = 32;
  localparam int unsigned DEFAULT_BASE_ADDR = 1024;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/sram_controller.sv
// Splits 32-bit pipeline word accesses into two 16-bit SRAM accesses (low half
// first), then idles WAIT_CYCLES cycles before signalling ready.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WORD_W-1:0]      address,
  input  logic [WORD_W-1:0]      write_data,
  output logic [WORD_W-1:0]      read_data,
  output logic                   ready,
  output logic                   SRAM_WE_N,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ
);

  state_t                 state, state_next;
  logic [3:0]             wait_cnt;
  logic                   op_wr;
  logic [SRAM_ADDR_W-2:0] word_off;
  logic [WORD_W-1:0]      wdata;

  logic [WORD_W-1:0]      offset_calc;
  logic                   req;
  logic                   dq_oe;
  logic [SRAM_DATA_W-1:0] dq_out;
  logic                   wait_last;
  logic                   unused_offset_bits;

  assign req         = wr_en | rd_en;
  assign offset_calc = address - WORD_W'(BASE_ADDR);
  assign wait_last   = (wait_cnt == 4'(WAIT_CYCLES - 1));

  // Only the halfword index bits of the 32-bit offset reach the SRAM.
  assign unused_offset_bits = ^{offset_calc[WORD_W-1:SRAM_ADDR_W+1], offset_calc[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_wr    <= 1'b0;
      word_off <= '0;
      wdata    <= '0;
    end else if (state == IDLE && req) begin
      op_wr    <= wr_en;
      word_off <= offset_calc[SRAM_ADDR_W:2];
      wdata    <= write_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !wait_last) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Each half is captured at the edge closing its access cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (!op_wr) begin
      if (state == LO) begin
        read_data[SRAM_DATA_W-1:0] <= SRAM_DQ;
      end else if (state == HI) begin
        read_data[WORD_W-1:SRAM_DATA_W] <= SRAM_DQ;
      end
    end
  end

  always_comb begin
    state_next = state;
    SRAM_WE_N  = 1'b1;
    SRAM_ADDR  = '0;
    dq_oe      = 1'b0;
    dq_out     = '0;
    ready      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = !req;
        if (req) state_next = LO;
      end
      LO: begin
        SRAM_ADDR  = {word_off, 1'b0};
        SRAM_WE_N  = !op_wr;
        dq_oe      = op_wr;
        dq_out     = wdata[SRAM_DATA_W-1:0];
        state_next = HI;
      end
      HI: begin
        SRAM_ADDR  = {word_off, 1'b1};
        SRAM_WE_N  = !op_wr;
        dq_oe      = op_wr;
        dq_out     = wdata[WORD_W-1:SRAM_DATA_W];
        state_next = (WAIT_CYCLES > 0) ? WAIT : DONE;
      end
      WAIT: begin
        if (wait_last) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign SRAM_DQ = dq_oe ? dq_out : 'z;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: default build plus a zero-wait build.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wr_en0, rd_en0, ready0, we_n0;
  logic [31:0] address0, write_data0, read_data0;
  logic [17:0] addr0;
  wire  [15:0] dq0;

  logic        wr_en1, rd_en1, ready1, we_n1;
  logic [31:0] address1, write_data1, read_data1;
  logic [17:0] addr1;
  wire  [15:0] dq1;

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(3)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en0), .rd_en(rd_en0), .address(address0),
    .write_data(write_data0), .read_data(read_data0), .ready(ready0),
    .SRAM_WE_N(we_n0), .SRAM_ADDR(addr0), .SRAM_DQ(dq0)
  );

  sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr_en1), .rd_en(rd_en1), .address(address1),
    .write_data(write_data1), .read_data(read_data1), .ready(ready1),
    .SRAM_WE_N(we_n1), .SRAM_ADDR(addr1), .SRAM_DQ(dq1)
  );

  // SRAM models: drive only when the bench enables output and WE_N is high.
  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];
  logic        sram_oe0, sram_oe1;
  logic        bd_we;
  int          bd_inst;
  logic [5:0]  bd_a;
  logic [15:0] bd_d;

  assign dq0 = (sram_oe0 && we_n0) ? mem0[addr0[5:0]] : 'z;
  assign dq1 = (sram_oe1 && we_n1) ? mem1[addr1[5:0]] : 'z;

  always @(posedge clk) begin
    if (bd_we && bd_inst == 0) mem0[bd_a] <= bd_d;
    else if (!we_n0) mem0[addr0[5:0]] <= dq0;
  end

  always @(posedge clk) begin
    if (bd_we && bd_inst == 1) mem1[bd_a] <= bd_d;
    else if (!we_n1) mem1[addr1[5:0]] <= dq1;
  end

  typedef struct {
    int          inst;
    int          exp_low;
    int          exp_we;
    logic [31:0] exp_rd;
  } item_t;

  item_t sb[$];
  int tests = 0;
  int fails = 0;
  int low_cnt [2];
  int we_cnt  [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic req, input logic rdy, input logic wen,
                     input logic [31:0] rd);
    item_t it;
    if (!wen) we_cnt[i]++;
    if (req) begin
      if (!rdy) begin
        low_cnt[i]++;
      end else begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: inst %0d completed with empty scoreboard", i);
        end else begin
          it = sb.pop_front();
          check("done_inst", i, it.inst);
          check("ready_low_cycles", low_cnt[i], it.exp_low);
          check("we_low_cycles", we_cnt[i], it.exp_we);
          check("read_data", rd, it.exp_rd);
        end
        low_cnt[i] = 0;
        we_cnt[i]  = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      low_cnt = '{0, 0};
      we_cnt  = '{0, 0};
    end else begin
      mon(0, wr_en0 | rd_en0, ready0, we_n0, read_data0);
      mon(1, wr_en1 | rd_en1, ready1, we_n1, read_data1);
    end
  end

  task automatic start(input int i, input logic wr, input logic rd,
                       input logic [31:0] a, input logic [31:0] d);
    if (i == 0) begin
      wr_en0 = wr; rd_en0 = rd; address0 = a; write_data0 = d;
    end else begin
      wr_en1 = wr; rd_en1 = rd; address1 = a; write_data1 = d;
    end
  endtask

  // Returns at the negedge where ready is seen (DONE), inputs still asserted.
  task automatic wait_ready(input int i);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((i == 0) ? ready0 : ready1) return;
    end
    tests++;
    fails++;
    $display("FAIL ready_timeout: inst %0d got ready=0 expected 1 within 40 cycles", i);
  endtask

  task automatic finish_txn(input int i);
    wait_ready(i);
    @(posedge clk);
    #1 start(i, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic backdoor(input int i, input logic [5:0] a, input logic [15:0] d);
    bd_inst = i; bd_a = a; bd_d = d; bd_we = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bd_we = 1'b0; bd_inst = 0; bd_a = '0; bd_d = '0;
    sram_oe0 = 1'b0; sram_oe1 = 1'b0;
    start(0, 1'b0, 1'b0, 32'h0, 32'h0);
    start(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    check("rst_ready", ready0, 1);
    check("rst_we_n", we_n0, 1);
    check("rst_sram_addr", addr0, 0);
    check("rst_read_data", read_data0, 0);
    check("rst_read_data_w0", read_data1, 0);
    @(posedge clk);
    #1;

    // Write 0xDEADBEEF to byte 1032 -> halfwords 4,5.
    sb.push_back('{0, 6, 2, 32'h0});
    start(0, 1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
    finish_txn(0);
    check("wr_mem4", mem0[4], 32'hBEEF);
    check("wr_mem5", mem0[5], 32'hDEAD);

    // Read back from a preloaded SRAM.
    backdoor(0, 6'd4, 16'hBEEF);
    backdoor(0, 6'd5, 16'hDEAD);
    sram_oe0 = 1'b1;
    sb.push_back('{0, 6, 0, 32'hDEADBEEF});
    start(0, 1'b0, 1'b1, 32'd1032, 32'h0);
    finish_txn(0);
    sram_oe0 = 1'b0;

    // Both requests high: write wins, read_data untouched.
    sb.push_back('{0, 6, 2, 32'hDEADBEEF});
    start(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
    finish_txn(0);
    check("sim_mem0", mem0[0], 32'h5678);
    check("sim_mem1", mem0[1], 32'h1234);
    check("sim_read_data", read_data0, 32'hDEADBEEF);

    // Back-to-back: the read request is already up during DONE of the write.
    sb.push_back('{0, 6, 2, 32'hDEADBEEF});
    sb.push_back('{0, 6, 0, 32'hA5A55A5A});
    start(0, 1'b1, 1'b0, 32'd1028, 32'hA5A55A5A);
    wait_ready(0);
    #1 start(0, 1'b0, 1'b1, 32'd1028, 32'h0);
    sram_oe0 = 1'b1;
    finish_txn(0);
    sram_oe0 = 1'b0;
    check("b2b_mem2", mem0[2], 32'h5A5A);
    check("b2b_mem3", mem0[3], 32'hA5A5);

    // Reset during HI of a write: only the low half lands.
    start(0, 1'b1, 1'b0, 32'd1032, 32'h11112222);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("abort_we_n", we_n0, 1);
    check("abort_ready", ready0, 1);
    check("abort_read_data", read_data0, 0);
    check("abort_sram_addr", addr0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("abort_mem4", mem0[4], 32'h2222);
    check("abort_mem5", mem0[5], 32'hDEAD);

    // Zero-wait build: DONE in cycle 3, address latched at acceptance.
    backdoor(1, 6'd16, 16'h3333);
    backdoor(1, 6'd17, 16'h4444);
    sram_oe1 = 1'b1;
    sb.push_back('{1, 3, 0, 32'h44443333});
    start(1, 1'b0, 1'b1, 32'd1056, 32'h0);
    @(posedge clk);
    #1 address1 = 32'd1024;
    @(negedge clk);
    check("w0_lo_addr", addr1, 16);
    @(negedge clk);
    check("w0_hi_addr", addr1, 17);
    finish_txn(1);
    sram_oe1 = 1'b0;

    repeat (2) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
